nmcu_mshr_file: RTL and testbench

- Miss Status Holding Register file between the NMCU cache controller (upstream) and the memory interface (downstream).
- Accepts primary cache misses and issues one line-read per miss to memory.
- Captures the returned line and hands it back to the cache as a fill.
- Entry state encoding matches the mshr_state_e enumeration: IDLE=00, PENDING=01, WAITING=10, COMPLETE=11.

---
 rtl/nmcu_mshr_file.sv | 177 +++++++++++++++++
 tb/tb_nmcu_mshr_file.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nmcu_mshr_file.sv
// Miss Status Holding Register file: tracks outstanding line misses from allocation
// through memory request, response capture and fill hand-back to the cache.
module nmcu_mshr_file #(
    parameter int NUM_ENTRIES = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 512,
    parameter int OFFSET_BITS = 6,
    parameter int ID_WIDTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           alloc_valid,
    output logic                           alloc_ready,
    input  logic [ADDR_WIDTH-1:0]          alloc_addr,
    input  logic [ID_WIDTH-1:0]            alloc_id,
    output logic                           alloc_conflict,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr,
    output logic [$clog2(NUM_ENTRIES)-1:0] mem_req_tag,
    input  logic                           mem_resp_valid,
    input  logic [$clog2(NUM_ENTRIES)-1:0] mem_resp_tag,
    input  logic [LINE_WIDTH-1:0]          mem_resp_data,
    input  logic                           mem_resp_error,
    output logic                           fill_valid,
    input  logic                           fill_ready,
    output logic [ADDR_WIDTH-1:0]          fill_addr,
    output logic [LINE_WIDTH-1:0]          fill_data,
    output logic [ID_WIDTH-1:0]            fill_id,
    output logic                           fill_error,
    output logic [$clog2(NUM_ENTRIES):0]   occupancy,
    output logic                           full,
    output logic                           proto_err
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int OCC_W = IDX_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PENDING  = 2'b01,
        WAITING  = 2'b10,
        COMPLETE = 2'b11
    } mshr_state_e;

    typedef struct packed {
        mshr_state_e           state;
        logic [ADDR_WIDTH-1:0] addr;
        logic [ID_WIDTH-1:0]   id;
        logic                  err;
        logic [LINE_WIDTH-1:0] data;
    } entry_t;

    entry_t             ent_q [NUM_ENTRIES];
    entry_t             ent_d [NUM_ENTRIES];
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               proto_err_q, proto_err_d;
    logic               issue_lock_q, issue_lock_d;
    logic [IDX_W-1:0]   issue_ptr_q, issue_ptr_d;
    logic               fill_lock_q, fill_lock_d;
    logic [IDX_W-1:0]   fill_ptr_q, fill_ptr_d;

    logic [IDX_W-1:0]   alloc_idx, issue_first, fill_first, issue_idx, fill_idx;
    logic               issue_any, fill_any;
    logic               alloc_fire, issue_fire, fill_fire, resp_ok;

    // Priority scan: iterating downwards leaves the lowest matching index selected.
    always_comb begin : scan_c
        // NOTE: every combinational output gets a default before any conditional
        // assignment, so no path leaves it unassigned and no latch is inferred.
        alloc_idx      = '0;
        issue_first    = '0;
        issue_any      = 1'b0;
        fill_first     = '0;
        fill_any       = 1'b0;
        alloc_conflict = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ent_q[i].state == IDLE) begin
                alloc_idx = IDX_W'(i);
            end
            if (ent_q[i].state == PENDING) begin
                issue_first = IDX_W'(i);
                issue_any   = 1'b1;
            end
            if (ent_q[i].state == COMPLETE) begin
                fill_first = IDX_W'(i);
                fill_any   = 1'b1;
            end
            if (ent_q[i].state != IDLE &&
                ((ent_q[i].addr ^ alloc_addr) & LINE_MASK) == '0) begin
                alloc_conflict = 1'b1;
            end
        end
    end

    assign full        = (occ_q == OCC_W'(NUM_ENTRIES));
    assign occupancy   = occ_q;
    assign proto_err   = proto_err_q;
    assign alloc_ready = !full && !alloc_conflict;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // A stalled request or fill keeps its entry even if a lower index becomes eligible.
    assign issue_idx     = issue_lock_q ? issue_ptr_q : issue_first;
    assign mem_req_valid = issue_lock_q || issue_any;
    assign mem_req_addr  = ent_q[issue_idx].addr;
    assign mem_req_tag   = issue_idx;
    assign issue_fire    = mem_req_valid && mem_req_ready;

    assign fill_idx   = fill_lock_q ? fill_ptr_q : fill_first;
    assign fill_valid = fill_lock_q || fill_any;
    assign fill_addr  = ent_q[fill_idx].addr;
    assign fill_data  = ent_q[fill_idx].data;
    assign fill_id    = ent_q[fill_idx].id;
    assign fill_error = ent_q[fill_idx].err;
    assign fill_fire  = fill_valid && fill_ready;

    assign resp_ok = mem_resp_valid && (ent_q[mem_resp_tag].state == WAITING);

    // The four events always target entries in distinct states, so they never collide.
    always_comb begin : next_c
        ent_d        = ent_q;
        issue_lock_d = mem_req_valid && !mem_req_ready;
        issue_ptr_d  = issue_idx;
        fill_lock_d  = fill_valid && !fill_ready;
        fill_ptr_d   = fill_idx;
        proto_err_d  = proto_err_q || (mem_resp_valid && !resp_ok);
        occ_d        = occ_q + OCC_W'(alloc_fire) - OCC_W'(fill_fire);

        if (alloc_fire) begin
            ent_d[alloc_idx].state = PENDING;
            ent_d[alloc_idx].addr  = alloc_addr & LINE_MASK;
            ent_d[alloc_idx].id    = alloc_id;
        end
        if (issue_fire) begin
            ent_d[issue_idx].state = WAITING;
        end
        if (resp_ok) begin
            ent_d[mem_resp_tag].state = COMPLETE;
            ent_d[mem_resp_tag].data  = mem_resp_data;
            ent_d[mem_resp_tag].err   = mem_resp_error;
        end
        if (fill_fire) begin
            ent_d[fill_idx].state = IDLE;
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the entry storage is cleared on reset so fill_* outputs are
            // deterministic zeros; the fields are small enough to sit in flops.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            occ_q        <= '0;
            proto_err_q  <= 1'b0;
            issue_lock_q <= 1'b0;
            issue_ptr_q  <= '0;
            fill_lock_q  <= 1'b0;
            fill_ptr_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
            occ_q        <= occ_d;
            proto_err_q  <= proto_err_d;
            issue_lock_q <= issue_lock_d;
            issue_ptr_q  <= issue_ptr_d;
            fill_lock_q  <= fill_lock_d;
            fill_ptr_q   <= fill_ptr_d;
        end
    end

endmodule

// File: tb/tb_nmcu_mshr_file.sv
// Directed bench for nmcu_mshr_file: per-cycle vector table plus hand-built
// backpressure and mid-flight reset sequences.
module tb_nmcu_mshr_file;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         alloc_valid, alloc_ready, alloc_conflict;
    logic [31:0]  alloc_addr;
    logic [3:0]   alloc_id;
    logic         mem_req_valid, mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic [1:0]   mem_req_tag;
    logic         mem_resp_valid, mem_resp_error;
    logic [1:0]   mem_resp_tag;
    logic [511:0] mem_resp_data;
    logic         fill_valid, fill_ready, fill_error;
    logic [31:0]  fill_addr;
    logic [511:0] fill_data;
    logic [3:0]   fill_id;
    logic [2:0]   occupancy;
    logic         full, proto_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nmcu_mshr_file dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
        .alloc_id(alloc_id), .alloc_conflict(alloc_conflict),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
        .mem_resp_data(mem_resp_data), .mem_resp_error(mem_resp_error),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
        .fill_data(fill_data), .fill_id(fill_id), .fill_error(fill_error),
        .occupancy(occupancy), .full(full), .proto_err(proto_err)
    );

    typedef struct {
        logic        av;    logic [31:0] aaddr; logic [3:0] aid;  logic mrdy;
        logic        rv;    logic [1:0]  rtag;  logic [7:0] rbyte; logic rerr; logic frdy;
        logic        ar;    logic        ac;    logic mv;  logic [31:0] maddr; logic [1:0] mtag;
        logic        fv;    logic [31:0] faddr; logic [3:0] fid; logic ferr; logic [7:0] fbyte;
        logic [2:0]  occ;   logic        full;  logic perr;
    } vec_t;

    vec_t tbl[$];
    vec_t hnd[$];

    function automatic vec_t mk(
        int unsigned av, int unsigned aaddr, int unsigned aid, int unsigned mrdy,
        int unsigned rv, int unsigned rtag, int unsigned rbyte, int unsigned rerr,
        int unsigned frdy, int unsigned ar, int unsigned ac, int unsigned mv,
        int unsigned maddr, int unsigned mtag, int unsigned fv, int unsigned faddr,
        int unsigned fid, int unsigned ferr, int unsigned fbyte, int unsigned occ,
        int unsigned fl, int unsigned perr);
        vec_t t;
        t.av = 1'(av);     t.aaddr = aaddr;     t.aid = 4'(aid);    t.mrdy = 1'(mrdy);
        t.rv = 1'(rv);     t.rtag = 2'(rtag);   t.rbyte = 8'(rbyte); t.rerr = 1'(rerr);
        t.frdy = 1'(frdy); t.ar = 1'(ar);       t.ac = 1'(ac);      t.mv = 1'(mv);
        t.maddr = maddr;   t.mtag = 2'(mtag);   t.fv = 1'(fv);      t.faddr = faddr;
        t.fid = 4'(fid);   t.ferr = 1'(ferr);   t.fbyte = 8'(fbyte); t.occ = 3'(occ);
        t.full = 1'(fl);   t.perr = 1'(perr);
        return t;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string n);
        @(posedge clk);
        #2;
        alloc_valid    = t.av;
        alloc_addr     = t.aaddr;
        alloc_id       = t.aid;
        mem_req_ready  = t.mrdy;
        mem_resp_valid = t.rv;
        mem_resp_tag   = t.rtag;
        mem_resp_data  = {64{t.rbyte}};
        mem_resp_error = t.rerr;
        fill_ready     = t.frdy;
        #1;
        check({n, ".alloc_ready"},    512'(alloc_ready),    512'(t.ar));
        check({n, ".alloc_conflict"}, 512'(alloc_conflict), 512'(t.ac));
        check({n, ".mem_req_valid"},  512'(mem_req_valid),  512'(t.mv));
        check({n, ".fill_valid"},     512'(fill_valid),     512'(t.fv));
        check({n, ".occupancy"},      512'(occupancy),      512'(t.occ));
        check({n, ".full"},           512'(full),           512'(t.full));
        check({n, ".proto_err"},      512'(proto_err),      512'(t.perr));
        if (t.mv) begin
            check({n, ".mem_req_addr"}, 512'(mem_req_addr), 512'(t.maddr));
            check({n, ".mem_req_tag"},  512'(mem_req_tag),  512'(t.mtag));
        end
        if (t.fv) begin
            check({n, ".fill_addr"},  512'(fill_addr),  512'(t.faddr));
            check({n, ".fill_id"},    512'(fill_id),    512'(t.fid));
            check({n, ".fill_error"}, 512'(fill_error), 512'(t.ferr));
            check({n, ".fill_data"},  fill_data,        {64{t.fbyte}});
        end
    endtask

    task automatic check_reset_outputs(input string n);
        check({n, ".occupancy"},     512'(occupancy),     512'(0));
        check({n, ".full"},          512'(full),          512'(0));
        check({n, ".mem_req_valid"}, 512'(mem_req_valid), 512'(0));
        check({n, ".fill_valid"},    512'(fill_valid),    512'(0));
        check({n, ".proto_err"},     512'(proto_err),     512'(0));
        check({n, ".fill_addr"},     512'(fill_addr),     512'(0));
        check({n, ".fill_data"},     fill_data,           512'(0));
        check({n, ".alloc_ready"},   512'(alloc_ready),   512'(1));
    endtask

    initial begin
        //                  av aaddr     id rdy rv tg rb   re fr ar ac mv maddr     mt fv faddr     fid fe fb   oc fl pe
        // single miss, conflict visibility
        tbl.push_back(mk(1, 'h1234, 3, 0, 0, 0, 'h00, 0, 0, 1, 0, 0, 0,        0, 0, 0,        0, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(1, 'h123F, 0, 1, 0, 0, 'h00, 0, 0, 0, 1, 1, 'h1200,   0, 0, 0,        0, 0, 'h00, 1, 0, 0));
        tbl.push_back(mk(0, 'h1240, 0, 0, 1, 0, 'hA5, 0, 0, 1, 0, 0, 0,        0, 0, 0,        0, 0, 'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0,      0, 0, 0, 0, 'h00, 0, 1, 1, 0, 0, 0,        0, 1, 'h1200,   3, 0, 'hA5, 1, 0, 0));
        tbl.push_back(mk(0, 0,      0, 0, 0, 0, 'h00, 0, 0, 1, 0, 0, 0,        0, 0, 0,        0, 0, 'h00, 0, 0, 0));
        // fill all four entries under request backpressure
        tbl.push_back(mk(1, 'h1000, 0, 0, 0, 0, 'h00, 0, 0, 1, 0, 0, 0,        0, 0, 0,        0, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(1, 'h2000, 1, 0, 0, 0, 'h00, 0, 0, 1, 0, 1, 'h1000,   0, 0, 0,        0, 0, 'h00, 1, 0, 0));
        tbl.push_back(mk(1, 'h3000, 2, 0, 0, 0, 'h00, 0, 0, 1, 0, 1, 'h1000,   0, 0, 0,        0, 0, 'h00, 2, 0, 0));
        tbl.push_back(mk(1, 'h4000, 3, 0, 0, 0, 'h00, 0, 0, 1, 0, 1, 'h1000,   0, 0, 0,        0, 0, 'h00, 3, 0, 0));
        tbl.push_back(mk(1, 'h5000, 0, 0, 0, 0, 'h00, 0, 0, 0, 0, 1, 'h1000,   0, 0, 0,        0, 0, 'h00, 4, 1, 0));
        tbl.push_back(mk(0, 'h5000, 0, 1, 0, 0, 'h00, 0, 0, 0, 0, 1, 'h1000,   0, 0, 0,        0, 0, 'h00, 4, 1, 0));
        tbl.push_back(mk(0, 0,      0, 1, 0, 0, 'h00, 0, 0, 0, 0, 1, 'h2000,   1, 0, 0,        0, 0, 'h00, 4, 1, 0));
        tbl.push_back(mk(0, 0,      0, 1, 0, 0, 'h00, 0, 0, 0, 0, 1, 'h3000,   2, 0, 0,        0, 0, 'h00, 4, 1, 0));
        tbl.push_back(mk(0, 0,      0, 1, 0, 0, 'h00, 0, 0, 0, 0, 1, 'h4000,   3, 0, 0,        0, 0, 'h00, 4, 1, 0));
        // complete entry 2, fill it while a 5th alloc waits; freed slot not reusable that cycle
        tbl.push_back(mk(0, 0,      0, 0, 1, 2, 'h22, 0, 0, 0, 0, 0, 0,        0, 0, 0,        0, 0, 'h00, 4, 1, 0));
        tbl.push_back(mk(1, 'h5000, 5, 0, 0, 0, 'h00, 0, 1, 0, 0, 0, 0,        0, 1, 'h3000,   2, 0, 'h22, 4, 1, 0));
        tbl.push_back(mk(1, 'h5000, 5, 0, 0, 0, 'h00, 0, 0, 1, 0, 0, 0,        0, 0, 0,        0, 0, 'h00, 3, 0, 0));
        // out-of-order returns, fill held stable under fill backpressure, error fill
        tbl.push_back(mk(0, 0,      0, 1, 1, 1, 'h11, 0, 0, 0, 0, 1, 'h5000,   2, 0, 0,        0, 0, 'h00, 4, 1, 0));
        tbl.push_back(mk(0, 0,      0, 0, 1, 0, 'h0A, 1, 0, 0, 0, 0, 0,        0, 1, 'h2000,   1, 0, 'h11, 4, 1, 0));
        tbl.push_back(mk(0, 0,      0, 0, 0, 0, 'h00, 0, 0, 0, 0, 0, 0,        0, 1, 'h2000,   1, 0, 'h11, 4, 1, 0));
        tbl.push_back(mk(0, 0,      0, 0, 0, 0, 'h00, 0, 1, 0, 0, 0, 0,        0, 1, 'h2000,   1, 0, 'h11, 4, 1, 0));
        tbl.push_back(mk(0, 0,      0, 0, 0, 0, 'h00, 0, 1, 1, 0, 0, 0,        0, 1, 'h1000,   0, 1, 'h0A, 3, 0, 0));
        tbl.push_back(mk(0, 0,      0, 0, 1, 3, 'h33, 0, 1, 1, 0, 0, 0,        0, 0, 0,        0, 0, 'h00, 2, 0, 0));
        tbl.push_back(mk(0, 0,      0, 0, 1, 2, 'h44, 0, 1, 1, 0, 0, 0,        0, 1, 'h4000,   3, 0, 'h33, 2, 0, 0));
        tbl.push_back(mk(0, 0,      0, 0, 0, 0, 'h00, 0, 1, 1, 0, 0, 0,        0, 1, 'h5000,   5, 0, 'h44, 1, 0, 0));
        // response to an IDLE entry
        tbl.push_back(mk(0, 0,      0, 0, 1, 3, 'h66, 0, 0, 1, 0, 0, 0,        0, 0, 0,        0, 0, 'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0,      0, 0, 0, 0, 'h00, 0, 0, 1, 0, 0, 0,        0, 0, 0,        0, 0, 'h00, 0, 0, 1));

        // stalled request on entry 1 must not be preempted by a new entry 0
        hnd.push_back(mk(1, 'h8000, 1, 0, 0, 0, 'h00, 0, 0, 1, 0, 0, 0,        0, 0, 0,        0, 0, 'h00, 0, 0, 1));
        hnd.push_back(mk(1, 'h9000, 2, 1, 0, 0, 'h00, 0, 0, 1, 0, 1, 'h8000,   0, 0, 0,        0, 0, 'h00, 1, 0, 1));
        hnd.push_back(mk(0, 0,      0, 0, 1, 0, 'h55, 0, 0, 1, 0, 1, 'h9000,   1, 0, 0,        0, 0, 'h00, 2, 0, 1));
        hnd.push_back(mk(0, 0,      0, 0, 0, 0, 'h00, 0, 1, 1, 0, 1, 'h9000,   1, 1, 'h8000,   1, 0, 'h55, 2, 0, 1));
        hnd.push_back(mk(1, 'hA000, 4, 0, 0, 0, 'h00, 0, 0, 1, 0, 1, 'h9000,   1, 0, 0,        0, 0, 'h00, 1, 0, 1));
        hnd.push_back(mk(0, 0,      0, 0, 0, 0, 'h00, 0, 0, 1, 0, 1, 'h9000,   1, 0, 0,        0, 0, 'h00, 2, 0, 1));
        hnd.push_back(mk(0, 0,      0, 0, 0, 0, 'h00, 0, 0, 1, 0, 1, 'h9000,   1, 0, 0,        0, 0, 'h00, 2, 0, 1));
        hnd.push_back(mk(0, 0,      0, 1, 0, 0, 'h00, 0, 0, 1, 0, 1, 'h9000,   1, 0, 0,        0, 0, 'h00, 2, 0, 1));
        hnd.push_back(mk(0, 0,      0, 1, 0, 0, 'h00, 0, 0, 1, 0, 1, 'hA000,   0, 0, 0,        0, 0, 'h00, 2, 0, 1));
        hnd.push_back(mk(0, 0,      0, 0, 0, 0, 'h00, 0, 0, 1, 0, 0, 0,        0, 0, 0,        0, 0, 'h00, 2, 0, 1));

        rst_n          = 1'b0;
        alloc_valid    = 1'b1;
        alloc_addr     = 32'h0000_1234;
        alloc_id       = 4'd3;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_tag   = 2'd0;
        mem_resp_data  = '0;
        mem_resp_error = 1'b0;
        fill_ready     = 1'b0;
        #3;
        check_reset_outputs("reset");
        check("reset.alloc_conflict", 512'(alloc_conflict), 512'(0));
        alloc_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end
        for (int i = 0; i < hnd.size(); i++) begin
            apply(hnd[i], $sformatf("bp%0d", i));
        end

        // asynchronous reset while entries 0 and 1 are WAITING
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #1;
        rst_n = 1'b1;

        // late response for a discarded entry
        apply(mk(0, 0, 0, 0, 1, 1, 'h77, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 0), "late0");
        apply(mk(0, 0, 0, 0, 0, 0, 'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 1), "late1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
